// File: rtl/mc_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 datapath.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
module mc_seq_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             run,
   output logic             imem_req,
   input  logic             imem_ready,
   output logic             ir_we,
   input  logic             dec_jal,
   input  logic             dec_jalr,
   input  logic             dec_br_taken,
   input  logic             dec_wb_en,
   input  logic             dec_mem_we,
   input  logic             dec_load,
   input  logic             dec_illegal,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ready,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             rf_we,
   output logic [2:0]       state,
   output logic             halted,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
   localparam bit TO_EN = (MEM_TIMEOUT > 0);

   state_t          st;
   logic [TO_W-1:0] to_cnt;
   logic            retire;
   logic            to_hit;

   assign state  = st;
   assign to_hit = TO_EN && (to_cnt == TO_LAST);

   // Strobes that must coincide with a ready input are decoded from the current cycle.
   assign ir_we  = imem_req & imem_ready;
   assign retire = (st == S_EXEC && !(dec_load || dec_mem_we) && !dec_wb_en) ||
                   (st == S_MEM && dmem_ready && dmem_we) ||
                   (st == S_WB);
   assign pc_we  = retire;

   // NOTE: default assignment first so every path drives pc_sel and no latch is inferred.
   always_comb begin
      pc_sel = 2'b00;
      if (retire) begin
         if (dec_jalr)                     pc_sel = 2'b10;
         else if (dec_jal || dec_br_taken) pc_sel = 2'b01;
      end
   end

   // NOTE: state and registered outputs use non-blocking assignments; async reset clears requests at once.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st       <= S_IDLE;
         to_cnt   <= '0;
         imem_req <= 1'b0;
         dmem_req <= 1'b0;
         dmem_we  <= 1'b0;
         rf_we    <= 1'b0;
         halted   <= 1'b0;
         err_code <= 2'b00;
      end else begin
         rf_we <= 1'b0;
         unique case (st)
            S_IDLE: begin
               if (run) begin
                  st       <= S_FETCH;
                  imem_req <= 1'b1;
                  to_cnt   <= '0;
               end
            end
            S_FETCH: begin
               if (imem_ready) begin
                  st       <= S_DECODE;
                  imem_req <= 1'b0;
               end else if (to_hit) begin
                  st       <= S_HALT;
                  imem_req <= 1'b0;
                  halted   <= 1'b1;
                  err_code <= 2'b10;
               end else if (TO_EN) begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_DECODE: begin
               if (dec_illegal) begin
                  st       <= S_HALT;
                  halted   <= 1'b1;
                  err_code <= 2'b01;
               end else begin
                  st <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (dec_load || dec_mem_we) begin
                  st       <= S_MEM;
                  dmem_req <= 1'b1;
                  dmem_we  <= dec_mem_we;
                  to_cnt   <= '0;
               end else if (dec_wb_en) begin
                  st    <= S_WB;
                  rf_we <= 1'b1;
               end
            end
            S_MEM: begin
               if (dmem_ready) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  if (!dmem_we) begin
                     st    <= S_WB;
                     rf_we <= 1'b1;
                  end
               end else if (to_hit) begin
                  st       <= S_HALT;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  halted   <= 1'b1;
                  err_code <= 2'b11;
               end else if (TO_EN) begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_WB:    st <= S_WB;
            S_HALT:  st <= S_HALT;
            default: st <= S_IDLE;
         endcase

         // Retire overrides the per-state next state: continue or park at the boundary.
         if (retire) begin
            if (run) begin
               st       <= S_FETCH;
               imem_req <= 1'b1;
               to_cnt   <= '0;
            end else begin
               st <= S_IDLE;
            end
         end
      end
   end

`ifdef MC_PERF_CNT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (st != S_IDLE && st != S_HALT) cycle_cnt <= cycle_cnt + 1'b1;
         if (pc_we)                        instret_cnt <= instret_cnt + 1'b1;
      end
   end
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Scoreboard bench for mc_seq_ctrl: expected retire records are queued per
// instruction and compared when the sequencer retires it.
module tb_mc_seq_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        run;
   logic        imem_req, imem_ready, ir_we;
   logic        dec_jal, dec_jalr, dec_br_taken, dec_wb_en, dec_mem_we, dec_load, dec_illegal;
   logic        dmem_req, dmem_we, dmem_ready;
   logic        pc_we, rf_we, halted;
   logic [1:0]  pc_sel, err_code;
   logic [2:0]  state;
   logic [31:0] cycle_cnt, instret_cnt;

   int checks = 0;
   int errors = 0;

`ifdef MC_PERF_CNT_EN
   localparam int EXP_CYC = 8;
   localparam int EXP_RET = 2;
`else
   localparam int EXP_CYC = 0;
   localparam int EXP_RET = 0;
`endif

   typedef enum {K_ALU, K_LOAD, K_STORE, K_BR_T, K_BR_N, K_JAL, K_JALR, K_NOP} kind_t;
   typedef struct {
      logic [1:0] pc_sel;
      int         rf_pulses;
      int         lat;
      int         dreq;
      logic       dwe;
   } rec_t;

   rec_t       sb[$];
   logic [2:0] trace[$];

   always #5 clk = ~clk;

   mc_seq_ctrl #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
      .clk(clk), .rstn(rstn), .run(run),
      .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we),
      .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_br_taken(dec_br_taken),
      .dec_wb_en(dec_wb_en), .dec_mem_we(dec_mem_we), .dec_load(dec_load),
      .dec_illegal(dec_illegal),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
      .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .state(state),
      .halted(halted), .err_code(err_code),
      .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   // Reference timing model derived from the instruction class and memory waits.
   function automatic rec_t model(input kind_t k, input int iw, input int dw);
      rec_t r;
      bit   mem;
      mem = (k == K_LOAD) || (k == K_STORE);
      case (k)
         K_LOAD:                    r.lat = 5;
         K_BR_T, K_BR_N, K_NOP:     r.lat = 3;
         default:                   r.lat = 4;
      endcase
      r.lat       = r.lat + iw + (mem ? dw : 0);
      r.dreq      = mem ? dw + 1 : 0;
      r.dwe       = (k == K_STORE);
      r.rf_pulses = (k == K_ALU || k == K_LOAD || k == K_JAL || k == K_JALR) ? 1 : 0;
      r.pc_sel    = (k == K_JALR) ? 2'b10 : (k == K_JAL || k == K_BR_T) ? 2'b01 : 2'b00;
      return r;
   endfunction

   task automatic set_dec(input kind_t k);
      dec_jal      = (k == K_JAL);
      dec_jalr     = (k == K_JALR);
      dec_br_taken = (k == K_BR_T);
      dec_wb_en    = (k == K_ALU || k == K_LOAD || k == K_JAL || k == K_JALR);
      dec_mem_we   = (k == K_STORE);
      dec_load     = (k == K_LOAD);
      dec_illegal  = 1'b0;
   endtask

   task automatic do_reset();
      rstn = 1'b0; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
      set_dec(K_NOP);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic start_run();
      run = 1'b1;
      @(posedge clk); #1;
   endtask

   // Drives one instruction from FETCH to retire; called at posedge+1 with state FETCH.
   task automatic exec_instr(input kind_t k, input int iw, input int dw, input bit drop_run);
      rec_t e, o;
      int   icnt, dcnt;
      bit   done;
      set_dec(k);
      sb.push_back(model(k, iw, dw));
      o.pc_sel = 2'b00; o.rf_pulses = 0; o.lat = 0; o.dreq = 0; o.dwe = 1'b0;
      trace.delete();
      icnt = 0; dcnt = 0; done = 1'b0;
      for (int c = 1; c <= 200 && !done; c++) begin
         imem_ready = 1'b0;
         dmem_ready = 1'b0;
         if (imem_req) begin
            if (icnt < iw) icnt++;
            else           imem_ready = 1'b1;
         end
         if (dmem_req) begin
            o.dreq++;
            if (dmem_we) o.dwe = 1'b1;
            if (dcnt < dw) dcnt++;
            else           dmem_ready = 1'b1;
         end
         if (drop_run && c == 2) run = 1'b0;
         #1;
         trace.push_back(state);
         if (rf_we) o.rf_pulses++;
         if (pc_we) begin
            o.lat    = c;
            o.pc_sel = pc_sel;
            done     = 1'b1;
         end
         @(posedge clk); #1;
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      e = sb.pop_front();
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL retire_timeout kind=%0d: no pc_we within 200 cycles", k);
      end else begin
         if (o.lat !== e.lat) begin
            errors++;
            $display("FAIL latency kind=%0d: got %0d expected %0d", k, o.lat, e.lat);
         end
         checks++;
         if (o.pc_sel !== e.pc_sel) begin
            errors++;
            $display("FAIL pc_sel kind=%0d: got %0b expected %0b", k, o.pc_sel, e.pc_sel);
         end
         checks++;
         if (o.rf_pulses !== e.rf_pulses) begin
            errors++;
            $display("FAIL rf_we_pulses kind=%0d: got %0d expected %0d", k, o.rf_pulses, e.rf_pulses);
         end
         checks++;
         if (o.dreq !== e.dreq) begin
            errors++;
            $display("FAIL dmem_req_cycles kind=%0d: got %0d expected %0d", k, o.dreq, e.dreq);
         end
         checks++;
         if (o.dwe !== e.dwe) begin
            errors++;
            $display("FAIL dmem_we kind=%0d: got %0b expected %0b", k, o.dwe, e.dwe);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (state !== 3'd0) begin
         errors++;
         $display("FAIL reset_state: got %0d expected 0", state);
      end
      checks++;
      if ({imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, halted, pc_sel, err_code} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected all zero",
                  {imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, halted, pc_sel, err_code});
      end
      checks++;
      if ({cycle_cnt, instret_cnt} !== 64'd0) begin
         errors++;
         $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycle_cnt, instret_cnt);
      end
   endtask

   task automatic test_alu();
      logic [2:0] exp_tr[4];
      exp_tr = '{3'd1, 3'd2, 3'd3, 3'd5};
      do_reset();
      start_run();
      exec_instr(K_ALU, 0, 0, 1'b1);
      checks++;
      if (trace.size() != 4) begin
         errors++;
         $display("FAIL alu_trace_len: got %0d expected 4", trace.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (trace[i] !== exp_tr[i]) begin
               errors++;
               $display("FAIL alu_trace[%0d]: got %0d expected %0d", i, trace[i], exp_tr[i]);
            end
         end
      end
      checks++;
      if (state !== 3'd0) begin
         errors++;
         $display("FAIL park_idle: got %0d expected 0", state);
      end
   endtask

   task automatic test_load_store();
      do_reset();
      start_run();
      exec_instr(K_LOAD, 0, 3, 1'b0);
      exec_instr(K_STORE, 0, 0, 1'b0);
      exec_instr(K_STORE, 2, 1, 1'b1);
   endtask

   task automatic test_branch_jump();
      do_reset();
      start_run();
      exec_instr(K_BR_T, 0, 0, 1'b0);
      exec_instr(K_JALR, 0, 0, 1'b0);
      exec_instr(K_JAL, 1, 0, 1'b0);
      exec_instr(K_BR_N, 0, 0, 1'b0);
      exec_instr(K_NOP, 0, 0, 1'b1);
   endtask

   task automatic test_back_to_back();
      do_reset();
      start_run();
      exec_instr(K_ALU, 0, 0, 1'b0);
      exec_instr(K_ALU, 0, 0, 1'b1);
      checks++;
      if (cycle_cnt !== 32'(EXP_CYC)) begin
         errors++;
         $display("FAIL cycle_cnt: got %0d expected %0d", cycle_cnt, EXP_CYC);
      end
      checks++;
      if (instret_cnt !== 32'(EXP_RET)) begin
         errors++;
         $display("FAIL instret_cnt: got %0d expected %0d", instret_cnt, EXP_RET);
      end
   endtask

   task automatic test_ready_wins();
      do_reset();
      start_run();
      exec_instr(K_ALU, 14, 0, 1'b0);
      exec_instr(K_LOAD, 0, 14, 1'b1);
      checks++;
      if (halted !== 1'b0) begin
         errors++;
         $display("FAIL ready_wins_halted: got %0b expected 0", halted);
      end
   endtask

   task automatic test_imem_timeout();
      int  nreq;
      bit  bad;
      do_reset();
      run  = 1'b1;
      nreq = 0;
      @(posedge clk); #1;
      for (int c = 0; c < 40 && state !== 3'd6; c++) begin
         if (imem_req) nreq++;
         @(posedge clk); #1;
      end
      checks++;
      if (nreq !== 15) begin
         errors++;
         $display("FAIL imem_timeout_cycles: got %0d expected 15", nreq);
      end
      checks++;
      if (err_code !== 2'b10) begin
         errors++;
         $display("FAIL imem_err_code: got %0b expected 10", err_code);
      end
      bad = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (halted !== 1'b1 || state !== 3'd6 || imem_req !== 1'b0 || pc_we !== 1'b0) bad = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL halt_sticky: got halted=%0b state=%0d expected 1/6", halted, state);
      end
   endtask

   task automatic test_dmem_timeout();
      int nreq;
      do_reset();
      set_dec(K_STORE);
      start_run();
      nreq = 0;
      for (int c = 0; c < 40 && state !== 3'd6; c++) begin
         imem_ready = imem_req;
         if (dmem_req) nreq++;
         @(posedge clk); #1;
      end
      imem_ready = 1'b0;
      checks++;
      if (nreq !== 15) begin
         errors++;
         $display("FAIL dmem_timeout_cycles: got %0d expected 15", nreq);
      end
      checks++;
      if (err_code !== 2'b11 || halted !== 1'b1) begin
         errors++;
         $display("FAIL dmem_err_code: got %0b halted=%0b expected 11/1", err_code, halted);
      end
   endtask

   task automatic test_illegal();
      int n;
      do_reset();
      set_dec(K_ALU);
      dec_illegal = 1'b1;
      start_run();
      n = 0;
      for (int c = 0; c < 10 && state !== 3'd6; c++) begin
         imem_ready = imem_req;
         n++;
         @(posedge clk); #1;
      end
      imem_ready = 1'b0;
      checks++;
      if (n !== 2 || err_code !== 2'b01) begin
         errors++;
         $display("FAIL illegal: got cycles=%0d err=%0b expected 2/01", n, err_code);
      end
   endtask

   task automatic test_reset_mid_mem();
      do_reset();
      set_dec(K_LOAD);
      start_run();
      for (int c = 0; c < 10 && state !== 3'd4; c++) begin
         imem_ready = imem_req;
         @(posedge clk); #1;
      end
      imem_ready = 1'b0;
      checks++;
      if (dmem_req !== 1'b1) begin
         errors++;
         $display("FAIL mem_reached: got dmem_req=%0b expected 1", dmem_req);
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (dmem_req !== 1'b0 || state !== 3'd0) begin
         errors++;
         $display("FAIL async_reset: got dmem_req=%0b state=%0d expected 0/0", dmem_req, state);
      end
      @(posedge clk); #1 rstn = 1'b1;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_store();
      test_branch_jump();
      test_back_to_back();
      test_ready_wins();
      test_imem_timeout();
      test_dmem_timeout();
      test_illegal();
      test_reset_mid_mem();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
